// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master: state encoding and divider limits.
package spi_pkg;

    // Smallest sck half-period (in clk cycles) a clk-synchronised slave can follow.
    localparam int SPI_MIN_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    function automatic bit spi_clk_div_ok(input int clk_div);
        return clk_div >= SPI_MIN_CLK_DIV;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Down-counting divider: one-cycle tick every CLK_DIV enabled clk cycles, restartable by clr_i.
module spi_clk_div #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one full-duplex DATA_WIDTH-bit word per start pulse, MSB first.
//
// state | meaning
// IDLE  | ss high, sck low, waiting for start
// SETUP | ss low, first mosi bit settling for CLK_DIV cycles
// SHIFT | sck toggling every CLK_DIV cycles, sample on rise, drive on fall
// HOLD  | sck low: trailing low half-period plus CLK_DIV hold before ss rises
// GAP   | ss high, busy still high so the slave can reload its word
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int BIT_CNT_WIDTH = 4,
    parameter int CLK_DIV       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ss,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    if (!spi_clk_div_ok(CLK_DIV)) begin : g_bad_clk_div
        $error("spi_master: CLK_DIV below SPI_MIN_CLK_DIV");
    end
    if ((2 ** BIT_CNT_WIDTH) != DATA_WIDTH) begin : g_bad_cnt_width
        $error("spi_master: 2**BIT_CNT_WIDTH must equal DATA_WIDTH");
    end

    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    spi_state_e state_q, state_d;

    logic                     ss_q, ss_d;
    logic                     sck_q, sck_d;
    logic                     mosi_q, mosi_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [DATA_WIDTH-1:0]    dout_q, dout_d;
    logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic                     tail_q, tail_d;
    logic                     lock_q, lock_d;

    logic div_en;
    logic div_clr;
    logic tick;

    assign div_en = (state_q != ST_IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (div_en),
        .clr_i  (div_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        ss_d      = ss_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dout_d    = dout_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tail_d    = tail_q;
        lock_d    = 1'b0;
        div_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ss_d      = 1'b1;
                sck_d     = 1'b0;
                bit_cnt_d = '0;
                tail_d    = 1'b0;
                // lock_q blocks a start in the first cycle busy reads low
                if (start && !lock_q) begin
                    shreg_d = din;
                    mosi_d  = din[DATA_WIDTH-1];
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_clr = 1'b1;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], miso};
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], miso};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_HOLD;
                        end else begin
                            mosi_d    = shreg_q[DATA_WIDTH-1];
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_HOLD: begin
                // First tick ends the final sck-low half-period, second ends the hold.
                if (tick) begin
                    if (!tail_q) begin
                        tail_d = 1'b1;
                    end else begin
                        ss_d    = 1'b1;
                        done_d  = 1'b1;
                        dout_d  = shreg_q;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    lock_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ss_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tail_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ss_q      <= ss_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tail_q    <= tail_d;
            lock_q    <= lock_d;
        end
    end

    assign ss   = ss_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of transfers plus reset, start-spam and CLK_DIV=4 sequences.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        sel;
    logic [1:0]  mmode;
    logic [15:0] din;

    logic        start8, busy8, done8, ss8, sck8, mosi8, miso8;
    logic [15:0] dout8;
    logic        start4, busy4, done4, ss4, sck4, mosi4, miso4;
    logic [15:0] dout4;

    logic [15:0] sl_tx, sl_sh, sl_rx, sl_dout;
    int          sl_done_cnt = 0;
    logic        ss_prev = 1'b1;
    logic        sck_prev = 1'b0;

    int total = 0;
    int bad   = 0;

    assign start8 = sel ? 1'b0 : start;
    assign start4 = sel ? start : 1'b0;
    assign miso8  = (mmode == 2'd0) ? mosi8 :
                    (mmode == 2'd1) ? sl_sh[15] :
                    (mmode == 2'd2);
    assign miso4  = 1'b1;

    spi_master #(.DATA_WIDTH(16), .BIT_CNT_WIDTH(4), .CLK_DIV(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .din(din), .busy(busy8), .done(done8),
        .dout(dout8), .ss(ss8), .sck(sck8), .mosi(mosi8), .miso(miso8)
    );

    spi_master #(.DATA_WIDTH(16), .BIT_CNT_WIDTH(4), .CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .din(din), .busy(busy4), .done(done4),
        .dout(dout4), .ss(ss4), .sck(sck4), .mosi(mosi4), .miso(miso4)
    );

    logic        m_busy, m_done, m_ss, m_sck, m_mosi;
    logic [15:0] m_dout;
    assign m_busy = sel ? busy4 : busy8;
    assign m_done = sel ? done4 : done8;
    assign m_ss   = sel ? ss4   : ss8;
    assign m_sck  = sel ? sck4  : sck8;
    assign m_mosi = sel ? mosi4 : mosi8;
    assign m_dout = sel ? dout4 : dout8;

    // clk-synchronised mode-0 slave attached to the CLK_DIV=8 master
    always @(negedge clk) begin
        if (ss_prev && !ss8) begin
            sl_sh <= sl_tx;
        end else if (!ss8 && sck_prev && !sck8) begin
            sl_sh <= {sl_sh[14:0], 1'b0};
        end
        if (!ss8 && !sck_prev && sck8) begin
            sl_rx <= {sl_rx[14:0], mosi8};
        end
        if (!ss_prev && ss8) begin
            sl_dout     <= sl_rx;
            sl_done_cnt <= sl_done_cnt + 1;
        end
        ss_prev  <= ss8;
        sck_prev <= sck8;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transfer on the selected master; cycle n is the n-th cycle after the accepting edge.
    task automatic run_xfer(input logic [15:0] d, output logic [15:0] got, output int done_c,
                            output int busy_c, output int rises, output int r1, output int r2,
                            output int mosi_bad, output int ss1);
        int   n;
        logic psck, pmosi;
        got = '0; done_c = -1; busy_c = -1; rises = 0; r1 = -1; r2 = -1; mosi_bad = 0; ss1 = -1;
        @(negedge clk);
        din = d;
        start = 1'b1;
        psck = m_sck;
        pmosi = m_mosi;
        n = 0;
        while (busy_c < 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                din = ~d;
                ss1 = int'(m_ss);
            end
            if (m_sck && !psck) begin
                rises++;
                if (r1 < 0) r1 = n;
                else if (r2 < 0) r2 = n;
                if (m_mosi !== pmosi) mosi_bad++;
            end
            if (m_done === 1'b1 && done_c < 0) begin
                done_c = n;
                got = m_dout;
            end
            if (m_busy === 1'b0 && busy_c < 0) busy_c = n;
            psck = m_sck;
            pmosi = m_mosi;
        end
    endtask

    typedef struct {
        logic [15:0] din;
        logic [1:0]  mode;
        logic [15:0] sl_tx;
        logic [15:0] exp_dout;
        logic [15:0] exp_srx;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [15:0] got;
        int          dc, bc, rs, r1, r2, mb, s1, cnt0, n, ss_falls, bfall, b282, b283, dn;
        logic        pss;

        vecs[0] = '{16'hA55A, 2'd0, 16'h0000, 16'hA55A, 16'h0000};
        vecs[1] = '{16'h5555, 2'd1, 16'h1234, 16'h1234, 16'h5555};
        vecs[2] = '{16'h0F0F, 2'd1, 16'hBEEF, 16'hBEEF, 16'h0F0F};
        vecs[3] = '{16'h7FFE, 2'd1, 16'h8001, 16'h8001, 16'h7FFE};
        vecs[4] = '{16'hFFFF, 2'd3, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'h1357, 2'd2, 16'h0000, 16'hFFFF, 16'h0000};

        sel = 1'b0; mmode = 2'd0; sl_tx = '0; sl_sh = '0; sl_rx = '0; sl_dout = '0;
        rst = 1'b1; start = 1'b1; din = 16'hFFFF;
        repeat (5) @(negedge clk);
        chk("rst_ss", ss8, 1'b1);
        chk("rst_sck", sck8, 1'b0);
        chk("rst_mosi", mosi8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_dout", dout8, 16'h0000);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_xfer_busy", busy8, 1'b0);
        chk("rst_no_xfer_ss", ss8, 1'b1);

        for (int i = 0; i < 6; i++) begin
            mmode = vecs[i].mode;
            sl_tx = vecs[i].sl_tx;
            cnt0 = sl_done_cnt;
            run_xfer(vecs[i].din, got, dc, bc, rs, r1, r2, mb, s1);
            chk($sformatf("v%0d_dout", i), got, vecs[i].exp_dout);
            chk($sformatf("v%0d_done_cyc", i), dc, 273);
            chk($sformatf("v%0d_busy_low_cyc", i), bc, 281);
            chk($sformatf("v%0d_sck_rises", i), rs, 16);
            chk($sformatf("v%0d_first_rise", i), r1, 9);
            chk($sformatf("v%0d_second_rise", i), r2, 25);
            chk($sformatf("v%0d_mosi_unstable", i), mb, 0);
            chk($sformatf("v%0d_ss_low_c1", i), s1, 0);
            if (vecs[i].mode == 2'd1) begin
                chk($sformatf("v%0d_slave_rx", i), sl_dout, vecs[i].exp_srx);
                chk($sformatf("v%0d_slave_done", i), sl_done_cnt - cnt0, 1);
            end
        end

        // start held high across a whole busy period and beyond
        mmode = 2'd0;
        @(negedge clk);
        din = 16'h3C3C; start = 1'b1;
        n = 0; ss_falls = 0; bfall = -1; b282 = -1; b283 = -1; pss = ss8;
        while (n < 283) begin
            @(negedge clk);
            n++;
            if (pss && !ss8 && n <= 281) ss_falls++;
            pss = ss8;
            if (busy8 == 1'b0 && bfall < 0) bfall = n;
            if (n == 282) b282 = int'(busy8);
            if (n == 283) b283 = int'(busy8);
        end
        start = 1'b0;
        chk("spam_one_xfer", ss_falls, 1);
        chk("spam_busy_fall", bfall, 281);
        chk("spam_not_at_fall", b282, 0);
        chk("spam_next_accept", b283, 1);
        n = 0; dn = 0;
        while (busy8 !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
            if (done8) dn++;
        end
        chk("spam_second_done", dn, 1);
        chk("spam_second_dout", dout8, 16'h3C3C);

        // reset at the 8th sck rising edge
        @(negedge clk);
        din = 16'hA5A5; start = 1'b1;
        n = 0; rs = 0; pss = sck8;
        while (rs < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (sck8 && !pss) rs++;
            pss = sck8;
        end
        chk("midrst_rises", rs, 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ss", ss8, 1'b1);
        chk("midrst_sck", sck8, 1'b0);
        chk("midrst_busy", busy8, 1'b0);
        chk("midrst_mosi", mosi8, 1'b0);
        chk("midrst_dout", dout8, 16'h0000);
        dn = 0;
        repeat (300) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("midrst_no_done", dn, 0);
        run_xfer(16'h00FF, got, dc, bc, rs, r1, r2, mb, s1);
        chk("after_rst_dout", got, 16'h00FF);
        chk("after_rst_done_cyc", dc, 273);

        // CLK_DIV=4 master with miso tied high
        sel = 1'b1;
        run_xfer(16'h5A3C, got, dc, bc, rs, r1, r2, mb, s1);
        chk("div4_dout", got, 16'hFFFF);
        chk("div4_done_cyc", dc, 137);
        chk("div4_busy_low_cyc", bc, 141);
        chk("div4_sck_rises", rs, 16);
        chk("div4_first_rise", r1, 5);
        chk("div4_sck_period", r2 - r1, 8);
        chk("div4_mosi_unstable", mb, 0);
        chk("div4_ss_low_c1", s1, 0);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
